bcam_match_ctrl: RTL

- Responder-side controller for BCAM match queries. Accepts match requests on a valid/ready interface and drives the BCAM match-pattern input.
- Tracks each query through the fixed BCAM match latency, captures match/mAddr, and returns one response per request on a valid/ready interface.
- Sits between request sources (switch/button front end, future UART/host bridge) and the bcam core; replaces ad-hoc mPatt loading.
- Credit-based, so responses are never dropped under back-pressure.

---
 rtl/bcam_pkg.sv | 28 ++
 rtl/bcam_rsp_fifo.sv | 66 ++++++
 rtl/bcam_match_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/bcam_pkg.sv
// Shared constants and types for the BCAM match path.
package bcam_pkg;

  localparam int CAMD_DEFAULT  = 256;
  localparam int CAMW_DEFAULT  = 16;
  localparam int ADDRW_DEFAULT = $clog2(CAMD_DEFAULT);

  // Match latency of the bcam core with registered match and registered
  // address encoder (REGM=1, REGO=1).
  localparam int MLAT_DEFAULT  = 2;
  localparam int RSPD_DEFAULT  = 4;

  typedef struct packed {
    logic                     hit;
    logic [ADDRW_DEFAULT-1:0] addr;
  } match_rsp_t;

  // Number of set bits in an up-to-8-bit valid vector (MLAT is at most 8).
  function automatic int unsigned popcount8(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bcam_rsp_fifo.sv
// Response FIFO: first-word-fall-through with a registered output stage.
// Entries land in the array first and reach the output register one cycle
// later, so the array read is always registered.
module bcam_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 9,
  localparam int PTRW  = $clog2(DEPTH),
  localparam int CNTW  = PTRW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTRW-1:0]  wr_ptr_reg;
  logic [PTRW-1:0]  rd_ptr_reg;
  logic [CNTW-1:0]  mem_cnt_reg;
  logic             out_vld_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             load;

  // Refill the output register whenever it is empty or being drained.
  assign load = (mem_cnt_reg != '0) && (!out_vld_reg || pop);

  // Storage array write port; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers, occupancy and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      mem_cnt_reg  <= '0;
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
    end else begin
      assert (!(push && !pop && count == CNTW'(DEPTH)));
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (load) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        out_data_reg <= mem_reg[rd_ptr_reg];
        out_vld_reg  <= 1'b1;
      end else if (pop) begin
        out_vld_reg  <= 1'b0;
      end
      mem_cnt_reg <= mem_cnt_reg + CNTW'(push) - CNTW'(load);
    end
  end

  assign out_valid = out_vld_reg;
  assign out_data  = out_data_reg;
  assign count     = mem_cnt_reg + CNTW'(out_vld_reg);

endmodule

// File: rtl/bcam_match_ctrl.sv
// BCAM match-query controller: drives mPatt, tracks queries through the
// fixed core latency and returns one response per accepted request.
module bcam_match_ctrl
  import bcam_pkg::*;
#(
  parameter  int CAMD  = CAMD_DEFAULT,
  parameter  int CAMW  = CAMW_DEFAULT,
  parameter  int ADDRW = $clog2(CAMD),
  parameter  int MLAT  = MLAT_DEFAULT,
  parameter  int RSPD  = RSPD_DEFAULT,
  localparam int CNTW  = $clog2(RSPD) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CAMW-1:0]  req_patt,
  input  logic             wr_busy,
  output logic [CAMW-1:0]  cam_mPatt,
  input  logic             cam_match,
  input  logic [ADDRW-1:0] cam_mAddr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_match,
  output logic [ADDRW-1:0] rsp_addr,
  output logic [15:0]      hit_cnt,
  output logic             busy
);

  logic             rst_q_reg;
  logic [MLAT-1:0]  vld_sr_reg;
  logic [MLAT-1:0]  vld_sr_next;
  logic [CAMW-1:0]  mpatt_reg;
  logic [15:0]      hit_cnt_reg;
  logic             accept;
  logic             push;
  logic             pop;
  logic             credit_ok;
  int unsigned      inflight;
  logic [ADDRW:0]   push_data;
  logic [ADDRW:0]   fifo_data;
  logic             fifo_valid;
  logic [CNTW-1:0]  fifo_count;

  // Credit check: every query in flight already owns a FIFO slot, so the
  // FIFO can never be full when a result arrives.
  always_comb begin
    inflight  = popcount8(8'(vld_sr_reg));
    credit_ok = (inflight + 32'(fifo_count)) < unsigned'(RSPD);
    req_ready = !rst_q_reg && !wr_busy && credit_ok;
  end

  assign accept = req_valid && req_ready;

  // Valid shift register: one stage per cycle of core match latency.
  for (genvar gi = 0; gi < MLAT; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      assign vld_sr_next[gi] = accept;
    end else begin : g_tail
      assign vld_sr_next[gi] = vld_sr_reg[gi-1];
    end
  end

  assign push      = vld_sr_reg[MLAT-1];
  assign push_data = {cam_match, cam_match ? cam_mAddr : {ADDRW{1'b0}}};
  assign pop       = fifo_valid && rsp_ready;

  // Query launch, latency tracking and delivered-hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q_reg   <= 1'b1;
      vld_sr_reg  <= '0;
      mpatt_reg   <= '0;
      hit_cnt_reg <= '0;
    end else begin
      rst_q_reg  <= 1'b0;
      vld_sr_reg <= vld_sr_next;
      if (accept) begin
        mpatt_reg <= req_patt;
      end
      if (pop && fifo_data[ADDRW] && hit_cnt_reg != 16'hFFFF) begin
        hit_cnt_reg <= hit_cnt_reg + 16'd1;
      end
    end
  end

  bcam_rsp_fifo #(
    .DEPTH (RSPD),
    .WIDTH (ADDRW + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign cam_mPatt = mpatt_reg;
  assign rsp_valid = fifo_valid;
  assign rsp_match = fifo_data[ADDRW];
  assign rsp_addr  = fifo_data[ADDRW-1:0];
  assign hit_cnt   = hit_cnt_reg;
  assign busy      = (|vld_sr_reg) || (fifo_count != '0);

endmodule
